// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests into the stall vector,
// sequences exception flushes with a refill mask, and tracks stall statistics.
module pipe_ctrl #(
    parameter logic [31:0] EXC_BASE      = 32'h0000_0020,
    parameter int          REFILL_CYCLES = 3,
    parameter int          STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        clr_cnt,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic        stall_timeout
);

    localparam logic [15:0] REFILL_LOAD = 16'(REFILL_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_VAL = 16'(STALL_TIMEOUT);

    typedef enum logic {
        RUN,
        REFILL
    } state_t;

    state_t      state_reg;
    logic [15:0] refill_cnt_reg;
    logic [31:0] new_pc_reg;
    logic [31:0] stall_cycles_reg;
    logic [15:0] run_cnt_reg;
    logic        timeout_reg;

    logic        accept;
    logic [5:0]  stall_req;
    logic [31:0] target_pc;
    logic [15:0] run_inc;

    // Gating with rst keeps every output quiet while reset is held.
    assign accept = !rst && (state_reg == RUN) && (excepttype_i != 32'd0);

    always_comb begin
        stall_req = 6'b000000;
        if (stallreq_from_mem) begin
            stall_req = 6'b011111;
        end else if (stallreq_from_ex) begin
            stall_req = 6'b001111;
        end else if (stallreq_from_id) begin
            stall_req = 6'b000111;
        end else if (stallreq_from_if) begin
            stall_req = 6'b000011;
        end
    end

    always_comb begin
        target_pc = EXC_BASE + 32'h20;
        if (excepttype_i == 32'h1) begin
            target_pc = EXC_BASE;
        end else if (excepttype_i == 32'hE) begin
            target_pc = cp0_epc_i;
        end
    end

    assign stall         = (rst || accept) ? 6'b000000 : stall_req;
    assign flush         = accept;
    assign new_pc        = rst ? 32'd0 : (accept ? target_pc : new_pc_reg);
    assign stall_cycles  = stall_cycles_reg;
    assign stall_timeout = timeout_reg;
    assign run_inc       = run_cnt_reg + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= RUN;
            refill_cnt_reg <= 16'd0;
            new_pc_reg     <= 32'd0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (accept) begin
                        state_reg      <= REFILL;
                        refill_cnt_reg <= REFILL_LOAD;
                        new_pc_reg     <= target_pc;
                    end
                end
                REFILL: begin
                    if (refill_cnt_reg == 16'd0) begin
                        state_reg <= RUN;
                    end else begin
                        refill_cnt_reg <= refill_cnt_reg - 16'd1;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    // Clear takes priority over any increment or watchdog set in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_reg <= 32'd0;
            run_cnt_reg      <= 16'd0;
            timeout_reg      <= 1'b0;
        end else if (clr_cnt) begin
            stall_cycles_reg <= 32'd0;
            run_cnt_reg      <= 16'd0;
            timeout_reg      <= 1'b0;
        end else if (stall[0]) begin
            if (stall_cycles_reg != 32'hFFFF_FFFF) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (run_cnt_reg != TIMEOUT_VAL) begin
                run_cnt_reg <= run_inc;
                if (run_inc == TIMEOUT_VAL) begin
                    timeout_reg <= 1'b1;
                end
            end
        end else begin
            run_cnt_reg <= 16'd0;
        end
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core. It merges per-stage stall requests into the 6-bit stall vector consumed by every pipeline register: PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also sequences exception flushes and the redirect PC, and keeps stall performance counters with a stuck-stall watchdog.

Parameters:
EXC_BASE, 32'h0000_0020, base address of the exception vector.
REFILL_CYCLES, 3, cycles after a flush during which the MEM-stage exception input is ignored (the pipeline is refilling).
STALL_TIMEOUT, 1024, consecutive stalled cycles that set the watchdog flag (range 1..65535).

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous, active-high reset (rst == `RstEnable).
stallreq_from_if  in  1  IF stage waiting on the instruction bus.
stallreq_from_id  in  1  load-use hazard.
stallreq_from_ex  in  1  multi-cycle mul/div busy.
stallreq_from_mem  in  1  MEM stage waiting on the data bus.
excepttype_i  in  32  exception type from MEM; 0 means none.
cp0_epc_i  in  32  current EPC from CP0.
clr_cnt  in  1  synchronous clear of the counters and the watchdog flag.
stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means `Stop.
flush  out  1  one-cycle flush of all pipeline registers.
new_pc  out  32  redirect target; valid while flush=1.
stall_cycles  out  32  saturating count of cycles with stall[0]=1.
stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, immediate): state RUN, refill counter 0, new_pc register 0, stall_cycles 0, run counter 0, stall_timeout 0. While rst=1: stall=6'b000000, flush=0, new_pc=0.
- stall and flush are combinational from the inputs and state (0-cycle latency), so the pipeline registers see them in the same cycle.
- Stall priority is highest first; only the highest active request applies:
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - if -> 6'b000011
  - none -> 6'b000000
- The ID/EX register inserts a bubble when stall[2]=1 and stall[3]=0; this encoding guarantees exactly one bubble boundary.
- Exception accept condition: state RUN and excepttype_i != 0.
- On accept, in that same cycle:
  - flush=1 and stall=6'b000000, overriding all stall requests.
  - new_pc is driven from the mapping below and latched into the register at the clock edge.
- new_pc mapping:
  - 32'h1 (interrupt) -> EXC_BASE.
  - 32'hE (eret) -> cp0_epc_i.
  - Any other nonzero value (syscall 8, invalid instruction A, overflow C, trap D, others) -> EXC_BASE + 32'h20.
- When flush=0, new_pc holds the last latched value.
- FSM:
  - RUN --accept--> REFILL, refill counter loaded with REFILL_CYCLES-1.
  - REFILL: excepttype_i ignored (flush=0). Stall requests are honoured normally. The counter decrements every cycle, whether stalled or not. When the counter is 0 -> RUN at the next edge.
  - REFILL_CYCLES=1 means exactly one masked cycle.
- stall_cycles: +1 on every edge where stall[0]=1; saturates at 32'hFFFF_FFFF.
- Watchdog run counter (16-bit):
  - +1 on each edge with stall[0]=1; reset to 0 on any edge with stall[0]=0.
  - When the incremented value equals STALL_TIMEOUT, stall_timeout <= 1 and stays 1.
  - The run counter saturates at STALL_TIMEOUT.
- clr_cnt=1 at an edge: stall_cycles, the run counter and stall_timeout all go to 0. Clear wins over a simultaneous increment or timeout set. The FSM is unaffected.
- Flush cycle: stall[0]=0, so the counters do not increment and the run counter resets.
- rst asserted mid-REFILL: immediate return to RUN, all counters zeroed.

Test Plan:
- stallreq_from_id=1 alone for 1 cycle -> stall=000111 that cycle, then 000000; stall_cycles=1.
- stallreq_from_if=1 and stallreq_from_ex=1 together -> stall=001111 (ex wins).
- excepttype_i=32'hC, EXC_BASE=32'h20 -> flush=1, new_pc=32'h40, stall=000000 the same cycle. With REFILL_CYCLES=3, excepttype_i=32'h1 held for the next 3 cycles gives flush=0; it is accepted on cycle 4 with new_pc=32'h20.
- excepttype_i=32'hE, cp0_epc_i=32'h0000_1234, stallreq_from_mem=1 in the same cycle -> flush=1, new_pc=32'h1234, stall=000000.
- STALL_TIMEOUT=4; stallreq_from_mem held for 4 cycles -> stall_timeout rises after the 4th edge and stays 1 after the request drops. Then clr_cnt=1 for 1 cycle -> stall_timeout=0, stall_cycles=0.
- rst pulsed asynchronously mid-REFILL with stallreq_from_ex=1 -> all outputs 0 immediately; after release, excepttype_i=32'h8 is accepted on the first cycle.
